// File: rtl/sayeh_pkg.sv
// Shared types and constants for the SAYEH memory responder.
package sayeh_pkg;

  localparam int WORD_W = 16;
  localparam int WAIT_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_READY = 2'd2
  } state_t;

endpackage

// File: rtl/mem_array.sv
// Word-wide storage: synchronous write, combinational read of the latched address.
import sayeh_pkg::*;

module mem_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [2**ADDR_W];

  // No reset: contents survive a responder reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Wait-state memory responder: posted writes, counted-latency reads.
import sayeh_pkg::*;

module mem_responder #(
  parameter int WAIT_STATES = WAIT_DEF,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              ExternalReset,
  input  logic              ReadMem,
  input  logic              WriteMem,
  input  logic [WORD_W-1:0] Address,
  input  logic [WORD_W-1:0] DataIn,
  output logic [WORD_W-1:0] DataOut,
  output logic              memDataReady,
  output logic              Busy
);

  localparam logic [3:0] WAIT_LD = 4'(WAIT_STATES);

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [WORD_W-1:0] dout_n;
  logic              rdy_n;
  logic [WORD_W-1:0] rdata;
  logic              unused_addr;

  assign unused_addr = ^Address[WORD_W-1:ADDR_W];

  mem_array #(.ADDR_W(ADDR_W)) u_mem (
    .clk  (clk),
    .we   (WriteMem),
    .waddr(Address[ADDR_W-1:0]),
    .wdata(DataIn),
    .raddr(addr),
    .rdata(rdata)
  );

  always_ff @(posedge clk or negedge ExternalReset) begin
    if (!ExternalReset) begin
      state        <= ST_IDLE;
      cnt          <= 4'd0;
      addr         <= '0;
      DataOut      <= '0;
      memDataReady <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      addr         <= addr_n;
      DataOut      <= dout_n;
      memDataReady <= rdy_n;
    end
  end

  // A zero count still passes through WAIT once, giving latency WAIT_STATES+1.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    addr_n  = addr;
    dout_n  = DataOut;
    rdy_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ReadMem && !WriteMem) begin
          addr_n  = Address[ADDR_W-1:0];
          cnt_n   = WAIT_LD;
          state_n = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (!ReadMem) begin
          state_n = ST_IDLE;
        end else if (cnt == 4'd0) begin
          state_n = ST_READY;
          rdy_n   = 1'b1;
          dout_n  = rdata;
        end else begin
          cnt_n = cnt - 4'd1;
        end
      end
      ST_READY: state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  assign Busy = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder (WAIT_STATES=2, ADDR_W=10).
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        ExternalReset;
  logic        ReadMem;
  logic        WriteMem;
  logic [15:0] Address;
  logic [15:0] DataIn;
  logic [15:0] DataOut;
  logic        memDataReady;
  logic        Busy;

  int n_checks = 0;
  int n_fail = 0;

  mem_responder #(.WAIT_STATES(2), .ADDR_W(10)) dut (
    .clk         (clk),
    .ExternalReset(ExternalReset),
    .ReadMem     (ReadMem),
    .WriteMem    (WriteMem),
    .Address     (Address),
    .DataIn      (DataIn),
    .DataOut     (DataOut),
    .memDataReady(memDataReady),
    .Busy        (Busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [15:0] a, input logic [15:0] d);
    WriteMem = 1'b1;
    Address  = a;
    DataIn   = d;
    tick();
    check("write_no_ready", 16'(memDataReady), 16'h0);
    WriteMem = 1'b0;
  endtask

  task automatic do_read(input string tag, input logic [15:0] a,
                         input logic [15:0] exp);
    ReadMem = 1'b1;
    Address = a;
    tick();
    check({tag, "_busy"}, 16'(Busy), 16'h1);
    tick();
    tick();
    check({tag, "_early"}, 16'(memDataReady), 16'h0);
    tick();
    check({tag, "_ready"}, 16'(memDataReady), 16'h1);
    check({tag, "_data"}, DataOut, exp);
    ReadMem = 1'b0;
    tick();
    check({tag, "_pulse_end"}, 16'(memDataReady), 16'h0);
  endtask

  initial begin
    ExternalReset = 1'b0;
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    Address  = 16'h0;
    DataIn   = 16'h0;
    #2;
    check("rst_dout", DataOut, 16'h0);
    check("rst_ready", 16'(memDataReady), 16'h0);
    check("rst_busy", 16'(Busy), 16'h0);
    #20;
    ExternalReset = 1'b1;
    tick();

    // Basic read after write, latency k+3
    do_write(16'd5, 16'hA5A5);
    ReadMem = 1'b1;
    Address = 16'd5;
    tick();
    check("rd5_busy_k", 16'(Busy), 16'h1);
    check("rd5_rdy_k", 16'(memDataReady), 16'h0);
    tick();
    check("rd5_rdy_k1", 16'(memDataReady), 16'h0);
    tick();
    check("rd5_rdy_k2", 16'(memDataReady), 16'h0);
    tick();
    check("rd5_rdy_k3", 16'(memDataReady), 16'h1);
    check("rd5_data", DataOut, 16'hA5A5);
    check("rd5_busy_ready", 16'(Busy), 16'h1);
    ReadMem = 1'b0;
    tick();
    check("rd5_rdy_off", 16'(memDataReady), 16'h0);
    check("rd5_busy_off", 16'(Busy), 16'h0);
    check("rd5_hold", DataOut, 16'hA5A5);

    // Back-to-back reads with ReadMem held through the IDLE gap
    do_write(16'd7, 16'h1111);
    do_write(16'd8, 16'h2222);
    ReadMem = 1'b1;
    Address = 16'd7;
    repeat (4) tick();
    check("b2b_first_rdy", 16'(memDataReady), 16'h1);
    check("b2b_first_data", DataOut, 16'h1111);
    Address = 16'd8;
    tick();
    check("b2b_gap_busy", 16'(Busy), 16'h0);
    check("b2b_gap_rdy", 16'(memDataReady), 16'h0);
    check("b2b_gap_hold", DataOut, 16'h1111);
    tick();
    check("b2b_second_busy", 16'(Busy), 16'h1);
    tick();
    tick();
    check("b2b_second_early", 16'(memDataReady), 16'h0);
    tick();
    check("b2b_second_rdy", 16'(memDataReady), 16'h1);
    check("b2b_second_data", DataOut, 16'h2222);
    ReadMem = 1'b0;
    tick();

    // Abort one cycle into WAIT
    ReadMem = 1'b1;
    Address = 16'd5;
    tick();
    tick();
    ReadMem = 1'b0;
    tick();
    check("abort_busy", 16'(Busy), 16'h0);
    check("abort_rdy", 16'(memDataReady), 16'h0);
    tick();
    tick();
    check("abort_rdy_later", 16'(memDataReady), 16'h0);
    check("abort_hold", DataOut, 16'h2222);

    // Simultaneous read+write: write wins, no read
    ReadMem  = 1'b1;
    WriteMem = 1'b1;
    Address  = 16'd3;
    DataIn   = 16'h1234;
    tick();
    check("rw_busy", 16'(Busy), 16'h0);
    check("rw_rdy", 16'(memDataReady), 16'h0);
    ReadMem  = 1'b0;
    WriteMem = 1'b0;
    tick();
    check("rw_rdy_later", 16'(memDataReady), 16'h0);
    do_read("rw_read3", 16'd3, 16'h1234);

    // Upper address bits alias
    do_write(16'h0403, 16'h5678);
    do_read("alias_read3", 16'd3, 16'h5678);
    do_read("alias_read803", 16'h0803, 16'h5678);

    // Write to the latched address during WAIT
    do_write(16'd9, 16'h0009);
    ReadMem = 1'b1;
    Address = 16'd9;
    tick();
    WriteMem = 1'b1;
    DataIn   = 16'hBEEF;
    tick();
    WriteMem = 1'b0;
    tick();
    check("wbr_early", 16'(memDataReady), 16'h0);
    tick();
    check("wbr_rdy", 16'(memDataReady), 16'h1);
    check("wbr_data", DataOut, 16'hBEEF);
    ReadMem = 1'b0;
    tick();

    // Asynchronous reset mid-read
    ReadMem = 1'b1;
    Address = 16'd5;
    tick();
    tick();
    #2;
    ExternalReset = 1'b0;
    #1;
    check("arst_dout", DataOut, 16'h0);
    check("arst_rdy", 16'(memDataReady), 16'h0);
    check("arst_busy", 16'(Busy), 16'h0);
    ReadMem = 1'b0;
    #10;
    ExternalReset = 1'b1;
    tick();
    check("arst_rel_rdy0", 16'(memDataReady), 16'h0);
    repeat (3) tick();
    check("arst_rel_rdy", 16'(memDataReady), 16'h0);
    check("arst_rel_busy", 16'(Busy), 16'h0);
    do_read("retain5", 16'd5, 16'hA5A5);
    do_read("retain3", 16'd3, 16'h5678);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
